// File: rtl/l2_arb_pkg.sv
// ============================================================================
// Module   : l2_arb_pkg
// Brief    : TileLink-UL opcodes and channel beat structs shared by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_arb_pkg;

  localparam logic [2:0] c_tl_get         = 3'd4;
  localparam logic [2:0] c_tl_put_full    = 3'd0;
  localparam logic [2:0] c_tl_put_partial = 3'd1;
  localparam logic [2:0] c_tl_ack         = 3'd0;
  localparam logic [2:0] c_tl_ack_data    = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [63:0] data;
  } tl_d_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb.sv
// ============================================================================
// Module   : rr_arb
// Brief    : Combinational round-robin grant; searches upward from ptr with wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb #(
  parameter int NUM_REQ  = 2,
  parameter int IDX_BITS = 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant
);

  int w_j;

  // Scan from farthest to nearest so the nearest requester at/after ptr wins.
  always_comb begin
    grant = '0;
    w_j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = (int'(ptr) + k) % NUM_REQ;
      if (req[w_j]) begin
        grant      = '0;
        grant[w_j] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_mem_arbiter.sv
// ============================================================================
// Module   : l2_mem_arbiter
// Brief    : Round-robin TL-UL A arbiter with registered slice, source tagging,
//            D demux and per-requester outstanding limits.
//            Optional: ARB_PERF_CNT_EN adds per-requester grant/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_mem_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int OP_BITS      = 3,
  parameter int SIZE_BITS    = 3,
  parameter int SOURCE_BITS  = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int DATA_BITS    = 64,
  parameter int MASK_BITS    = 8,
  parameter int MAX_OUTST    = 4,
  localparam int IDX_BITS    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_REQ-1:0]                in_a_valid,
  output logic [NUM_REQ-1:0]                in_a_ready,
  input  logic [NUM_REQ*OP_BITS-1:0]        in_a_opcode,
  input  logic [NUM_REQ*SIZE_BITS-1:0]      in_a_size,
  input  logic [NUM_REQ*SOURCE_BITS-1:0]    in_a_source,
  input  logic [NUM_REQ*ADDRESS_BITS-1:0]   in_a_address,
  input  logic [NUM_REQ*MASK_BITS-1:0]      in_a_mask,
  input  logic [NUM_REQ*DATA_BITS-1:0]      in_a_data,
  input  logic [NUM_REQ*3-1:0]              in_a_param,
  output logic [NUM_REQ-1:0]                in_d_valid,
  input  logic [NUM_REQ-1:0]                in_d_ready,
  output logic [NUM_REQ*OP_BITS-1:0]        in_d_opcode,
  output logic [NUM_REQ*SIZE_BITS-1:0]      in_d_size,
  output logic [NUM_REQ*SOURCE_BITS-1:0]    in_d_source,
  output logic [NUM_REQ*DATA_BITS-1:0]      in_d_data,
  output logic [NUM_REQ*3-1:0]              in_d_param,
  output logic                              mem_a_valid,
  input  logic                              mem_a_ready,
  output logic [OP_BITS-1:0]                mem_a_opcode,
  output logic [SIZE_BITS-1:0]              mem_a_size,
  output logic [SOURCE_BITS+IDX_BITS-1:0]   mem_a_source,
  output logic [ADDRESS_BITS-1:0]           mem_a_address,
  output logic [MASK_BITS-1:0]              mem_a_mask,
  output logic [DATA_BITS-1:0]              mem_a_data,
  output logic [2:0]                        mem_a_param,
  input  logic                              mem_d_valid,
  output logic                              mem_d_ready,
  input  logic [OP_BITS-1:0]                mem_d_opcode,
  input  logic [SIZE_BITS-1:0]              mem_d_size,
  input  logic [SOURCE_BITS+IDX_BITS-1:0]   mem_d_source,
  input  logic [DATA_BITS-1:0]              mem_d_data,
  input  logic [2:0]                        mem_d_param,
`ifdef ARB_PERF_CNT_EN
  output logic [NUM_REQ*32-1:0]             perf_grant_cnt,
  output logic [NUM_REQ*32-1:0]             perf_stall_cnt,
`endif
  output logic                              idle,
  output logic                              err_bad_idx
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] c_max_outst = CNT_W'(MAX_OUTST);

  logic [NUM_REQ-1:0][CNT_W-1:0] r_cnt;
  logic [IDX_BITS-1:0]           r_rr_ptr;
  logic                          r_mem_a_valid;
  logic [OP_BITS-1:0]            r_a_opcode;
  logic [SIZE_BITS-1:0]          r_a_size;
  logic [SOURCE_BITS+IDX_BITS-1:0] r_a_source;
  logic [ADDRESS_BITS-1:0]       r_a_address;
  logic [MASK_BITS-1:0]          r_a_mask;
  logic [DATA_BITS-1:0]          r_a_data;
  logic [2:0]                    r_a_param;
  logic                          r_err_bad_idx;

  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_d_hs;
  logic [NUM_REQ-1:0]  w_cnt_nz;
  logic [IDX_BITS-1:0] w_gnt_idx;
  logic [IDX_BITS-1:0] w_d_idx;
  logic                w_d_bad;
  logic                w_ld;
  int                  w_gi;

  // Eligibility reads the registered count, so a same-cycle D return cannot unblock.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign w_elig[i]   = in_a_valid[i] & (r_cnt[i] < c_max_outst);
    assign w_cnt_nz[i] = |r_cnt[i];
    assign in_d_valid[i] = mem_d_valid & (w_d_idx == IDX_BITS'(i));
    assign w_d_hs[i]   = in_d_valid[i] & in_d_ready[i];
  end

  rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_rr_arb (
    .req   (w_elig),
    .ptr   (r_rr_ptr),
    .grant (w_grant)
  );

  assign w_ld       = ~r_mem_a_valid | mem_a_ready;
  assign in_a_ready = {NUM_REQ{rstn & w_ld}} & w_grant;
  assign w_gi       = int'(w_gnt_idx);

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gnt_idx = IDX_BITS'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem_a_valid <= 1'b0;
      r_rr_ptr      <= '0;
      r_a_opcode    <= '0;
      r_a_size      <= '0;
      r_a_source    <= '0;
      r_a_address   <= '0;
      r_a_mask      <= '0;
      r_a_data      <= '0;
      r_a_param     <= '0;
    end else if (|in_a_ready) begin
      r_mem_a_valid <= 1'b1;
      r_a_opcode    <= in_a_opcode[w_gi*OP_BITS +: OP_BITS];
      r_a_size      <= in_a_size[w_gi*SIZE_BITS +: SIZE_BITS];
      r_a_source    <= {w_gnt_idx, in_a_source[w_gi*SOURCE_BITS +: SOURCE_BITS]};
      r_a_address   <= in_a_address[w_gi*ADDRESS_BITS +: ADDRESS_BITS];
      r_a_mask      <= in_a_mask[w_gi*MASK_BITS +: MASK_BITS];
      r_a_data      <= in_a_data[w_gi*DATA_BITS +: DATA_BITS];
      r_a_param     <= in_a_param[w_gi*3 +: 3];
      r_rr_ptr      <= (w_gnt_idx == IDX_BITS'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_BITS'(1);
    end else if (mem_a_ready) begin
      r_mem_a_valid <= 1'b0;
    end
  end

  assign mem_a_valid   = r_mem_a_valid;
  assign mem_a_opcode  = r_a_opcode;
  assign mem_a_size    = r_a_size;
  assign mem_a_source  = r_a_source;
  assign mem_a_address = r_a_address;
  assign mem_a_mask    = r_a_mask;
  assign mem_a_data    = r_a_data;
  assign mem_a_param   = r_a_param;

  // Out-of-range tags are sunk so a corrupt response cannot wedge the memory port.
  assign w_d_idx = mem_d_source[SOURCE_BITS +: IDX_BITS];
  assign w_d_bad = int'(w_d_idx) >= NUM_REQ;

  always_comb begin
    mem_d_ready = w_d_bad;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_d_idx == IDX_BITS'(i)) mem_d_ready = in_d_ready[i];
    end
  end

  assign in_d_opcode = {NUM_REQ{mem_d_opcode}};
  assign in_d_size   = {NUM_REQ{mem_d_size}};
  assign in_d_source = {NUM_REQ{mem_d_source[SOURCE_BITS-1:0]}};
  assign in_d_data   = {NUM_REQ{mem_d_data}};
  assign in_d_param  = {NUM_REQ{mem_d_param}};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err_bad_idx <= 1'b0;
    end else if (mem_d_valid & w_d_bad) begin
      r_err_bad_idx <= 1'b1;
    end
  end

  assign err_bad_idx = r_err_bad_idx;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (in_a_ready[i] & ~w_d_hs[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else if (w_d_hs[i] & ~in_a_ready[i] & (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  assign idle = ~r_mem_a_valid & ~|w_cnt_nz;

`ifdef ARB_PERF_CNT_EN
  logic [NUM_REQ*32-1:0] r_grant_cnt;
  logic [NUM_REQ*32-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (in_a_ready[i]) r_grant_cnt[i*32 +: 32] <= r_grant_cnt[i*32 +: 32] + 32'd1;
        if (in_a_valid[i] & ~in_a_ready[i]) r_stall_cnt[i*32 +: 32] <= r_stall_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end

  assign perf_grant_cnt = r_grant_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/l2_mem_arbiter.md
Name: l2_mem_arbiter

Overview:
Shares one downstream memory port among NUM_REQ L2 cache instances, each issuing TileLink-UL A requests and receiving D responses. Round-robin arbitration on A, one registered output slice, requester index tagged into the upper source bits, and D responses demuxed back by that tag. Per-requester outstanding limits keep one L2 from filling the memory model's queue. Sits between the per-L2 out_a/out_d buses and the single memory model or DRAM controller.

Parameters:
NUM_REQ, 2, number of L2 requesters (>=1)
OP_BITS, 3, opcode width
SIZE_BITS, 3, size field width
SOURCE_BITS, 4, upstream source ID width
ADDRESS_BITS, 32, address width
DATA_BITS, 64, data width
MASK_BITS, 8, byte mask width (DATA_BITS/8)
MAX_OUTST, 4, max in-flight requests per requester (>=1)
IDX_BITS, max(1,$clog2(NUM_REQ)), tag width (derived localparam)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
in_a_valid  in  NUM_REQ  per-requester A valid
in_a_ready  out  NUM_REQ  per-requester A ready
in_a_opcode/size/source/address/mask/data/param  in  NUM_REQ*field  packed A fields; param is 3 bits per requester
in_d_valid  out  NUM_REQ  per-requester D valid
in_d_ready  in  NUM_REQ  per-requester D ready
in_d_opcode/size/source/data/param  out  NUM_REQ*field  packed D fields, broadcast to every requester
mem_a_valid  out  1  downstream A valid (registered)
mem_a_ready  in  1
mem_a_opcode/size/address/mask/data/param  out  field  registered A fields
mem_a_source  out  SOURCE_BITS+IDX_BITS  {idx, source}
mem_d_valid  in  1
mem_d_ready  out  1
mem_d_opcode/size/data/param  in  field
mem_d_source  in  SOURCE_BITS+IDX_BITS
idle  out  1  stage empty and all outstanding counters zero
err_bad_idx  out  1  sticky: response carried idx >= NUM_REQ

Behaviour:
- Reset (rstn=0 at posedge): mem_a_valid=0, all A fields 0, rr_ptr=0, all counters 0, err_bad_idx=0, idle=1. In-flight requests are discarded; no responses are expected after reset.
- Eligible[i] = in_a_valid[i] & (cnt[i] < MAX_OUTST).
- Stage load enable: ld = ~mem_a_valid | mem_a_ready.
- Grant: round-robin over eligible requesters, searching from rr_ptr upward with wrap. in_a_ready[i] = ld & grant[i], one-hot or zero. in_a_ready does not depend on in_a_valid of the same requester beyond eligibility.
- On handshake for i: the stage captures i's fields, mem_a_source = {i, in_a_source[i]}, mem_a_valid=1 next cycle, rr_ptr = (i+1) mod NUM_REQ. Otherwise, if mem_a_ready, mem_a_valid=0. Throughput is one request per cycle with 1-cycle latency.
- D path is combinational. idx = mem_d_source[top IDX_BITS]. in_d_valid[idx] = mem_d_valid. mem_d_ready = in_d_ready[idx]. in_d_source = low SOURCE_BITS. Remaining fields pass through unchanged.
- idx >= NUM_REQ (non-power-of-2 NUM_REQ): mem_d_ready=1, no in_d_valid asserted, err_bad_idx set until reset.
- Counters: cnt[i] +1 on A handshake for i, -1 on D handshake for i, unchanged if both occur in the same cycle. Width $clog2(MAX_OUTST+1). No overflow is possible by construction. A D handshake while cnt[i]==0 is ignored (saturates at 0).
- Requester at MAX_OUTST is skipped and rr_ptr is not held for it. A simultaneous D return for that requester does not make it eligible in the same cycle, because eligibility uses the registered cnt.
- NUM_REQ=1: arbitration degenerates to pass-through with the register slice; the tag is 1 bit fixed at 0.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds 32-bit wrap-around counters per requester: grant_cnt[i] (A handshakes) and stall_cnt[i] (in_a_valid & ~in_a_ready). Exposed on out port perf_grant_cnt and perf_stall_cnt, each NUM_REQ*32 bits. Cleared by reset.
- Undefined: ports and logic are absent; function is otherwise identical.

Decomposition:
- Package l2_arb_pkg: TL opcodes (GET=4, PUT_FULL=0, PUT_PARTIAL=1, ACK=0, ACK_DATA=1), a packed struct for A-channel fields, and a packed struct for D-channel fields.
- Sub-module rr_arb: NUM_REQ-wide round-robin grant from req vector and rr_ptr, purely combinational; the pointer is kept in the parent.

Test Plan:
- Reset: rstn=0 for 2 cycles with in_a_valid=2'b11 -> in_a_ready=0, mem_a_valid=0, idle=1. First grant after release goes to requester 0.
- Contention: both valid continuously, mem_a_ready=1 -> mem_a_source tags alternate 0,1,0,1. One request per cycle, first mem_a_valid one cycle after the first handshake.
- Backpressure: mem_a_ready=0 for 5 cycles after one grant -> stage holds its fields, in_a_ready=0, and no further grants.
- Outstanding limit: req0 issues 4 GETs (addr 0x90000000+8k) with no responses -> req0 blocked and req1 still served. After one AccessAckData with source {0,src} -> req0 eligible on the next cycle.
- D routing: mem_d_source={1,4'h3}, data 0xDEADBEEF_CAFEF00D -> in_d_valid=2'b10, in_d_source[1]=3. in_d_ready[1]=0 stalls mem_d_ready.
- Bad idx: NUM_REQ=3, mem_d_source idx=3 -> mem_d_ready=1, no in_d_valid, err_bad_idx=1 until reset.
